// File: rtl/mem_stage.sv
// Memory stage: EXE/MEM pipeline register, word-addressed data RAM and a wait-state FSM.
// Optional feature macro: MEM_ALIGN_CHECK_EN adds mem_misalign and suppresses misaligned accesses.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic [31:0] ex_aluR,
    input  logic [31:0] ex_inB,
    input  logic [4:0]  ex_destR,
    input  logic [3:0]  EXE_ins_type,
    input  logic [3:0]  EXE_ins_number,
    output logic        mem_stall,
    output logic        mem_wreg,
    output logic        mem_m2reg,
    output logic [31:0] mem_aluR,
    output logic [31:0] mem_mdata,
    output logic [4:0]  mem_destR,
    output logic [3:0]  MEM_ins_type,
    output logic [3:0]  MEM_ins_number
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        mem_misalign
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    state_t      state, state_next;
    logic [3:0]  count, count_next;

    logic        r_wreg, r_m2reg, r_wmem;
    logic [31:0] r_aluR, r_inB;
    logic [4:0]  r_destR;
    logic [3:0]  r_type, r_number;

    logic [31:0] ram [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic        mem_op;
    logic        bad_align;
    logic        ram_we;

    assign word_idx = r_aluR[ADDR_W+1:2];
    assign mem_op   = r_m2reg | r_wmem;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_align    = mem_op & (r_aluR[1:0] != 2'b00);
    assign mem_misalign = bad_align;
`else
    assign bad_align = 1'b0;
`endif

    // Pipeline register only advances when the memory access is not holding the pipe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_aluR   <= '0;
            r_inB    <= '0;
            r_destR  <= '0;
            r_type   <= '0;
            r_number <= '0;
        end else if (!mem_stall) begin
            r_wreg   <= ex_wreg;
            r_m2reg  <= ex_m2reg;
            r_wmem   <= ex_wmem;
            r_aluR   <= ex_aluR;
            r_inB    <= ex_inB;
            r_destR  <= ex_destR;
            r_type   <= EXE_ins_type;
            r_number <= EXE_ins_number;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // The WAIT cycle with count==0 is the final access cycle: stall is released there,
    // so the total stall is exactly WAIT_STATES cycles.
    always_comb begin
        state_next = state;
        count_next = count;
        mem_stall  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op && (WS_L != 4'd0)) begin
                    mem_stall  = 1'b1;
                    state_next = S_WAIT;
                    count_next = WS_L - 4'd1;
                end
            end
            S_WAIT: begin
                if (count == 4'd0) begin
                    state_next = S_IDLE;
                end else begin
                    mem_stall  = 1'b1;
                    count_next = count - 4'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    // A store commits once, on the edge that leaves its unstalled final cycle.
    assign ram_we = rst & r_wmem & ~mem_stall & ~bad_align;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[word_idx] <= r_inB;
        end
    end

    assign mem_wreg       = r_wreg & ~mem_stall & ~(bad_align & r_m2reg);
    assign mem_m2reg      = r_m2reg;
    assign mem_aluR       = r_aluR;
    assign mem_mdata      = r_m2reg ? ram[word_idx] : 32'd0;
    assign mem_destR      = r_destR;
    assign MEM_ins_type   = r_type;
    assign MEM_ins_number = r_number;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: four instances with WAIT_STATES 0/2/3/4 share one input bus.
// Align-check scenarios are compiled in when MEM_ALIGN_CHECK_EN is defined.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_wreg, ex_m2reg, ex_wmem;
    logic [31:0] ex_aluR, ex_inB;
    logic [4:0]  ex_destR;
    logic [3:0]  EXE_ins_type, EXE_ins_number;

    logic        o_stall  [4];
    logic        o_wreg   [4];
    logic        o_m2reg  [4];
    logic [31:0] o_aluR   [4];
    logic [31:0] o_mdata  [4];
    logic [4:0]  o_destR  [4];
    logic [3:0]  o_type   [4];
    logic [3:0]  o_num    [4];
    logic        o_mis    [4];

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic [31:0] aluR;
        logic [31:0] mdata;
        logic [4:0]  destR;
        logic [3:0]  typ;
        logic [3:0]  num;
        logic        mis;
        int          stalls;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model_mem [4][256];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    function automatic int ws_of(input int inst);
        case (inst)
            0:       return 0;
            1:       return 2;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
        mem_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(WS)) dut (
            .clk            (clk),
            .rst            (rst),
            .ex_wreg        (ex_wreg),
            .ex_m2reg       (ex_m2reg),
            .ex_wmem        (ex_wmem),
            .ex_aluR        (ex_aluR),
            .ex_inB         (ex_inB),
            .ex_destR       (ex_destR),
            .EXE_ins_type   (EXE_ins_type),
            .EXE_ins_number (EXE_ins_number),
            .mem_stall      (o_stall[g]),
            .mem_wreg       (o_wreg[g]),
            .mem_m2reg      (o_m2reg[g]),
            .mem_aluR       (o_aluR[g]),
            .mem_mdata      (o_mdata[g]),
            .mem_destR      (o_destR[g]),
            .MEM_ins_type   (o_type[g]),
            .MEM_ins_number (o_num[g])
`ifdef MEM_ALIGN_CHECK_EN
            ,
            .mem_misalign   (o_mis[g])
`endif
        );
`ifndef MEM_ALIGN_CHECK_EN
        assign o_mis[g] = 1'b0;
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic driveNop();
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b0;
        ex_aluR = '0; ex_inB = '0; ex_destR = '0;
        EXE_ins_type = '0; EXE_ins_number = '0;
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        driveNop();
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one instruction at a negedge, predicts its MEM-stage result, then follows the
    // instance until its final (unstalled) cycle and compares against the scoreboard entry.
    task automatic applyStimulus(input int inst, input logic wreg, input logic m2reg, input logic wmem,
                                 input logic [31:0] alu, input logic [31:0] inb, input logic [4:0] dest,
                                 input logic [3:0] typ, input logic [3:0] num);
        exp_t e, got;
        logic mis;
        int   stalls;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (m2reg | wmem) && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        e.wreg   = wreg & ~(mis & m2reg);
        e.m2reg  = m2reg;
        e.aluR   = alu;
        e.mdata  = m2reg ? model_mem[inst][alu[9:2]] : 32'd0;
        e.destR  = dest;
        e.typ    = typ;
        e.num    = num;
        e.mis    = mis;
        e.stalls = (m2reg | wmem) ? ws_of(inst) : 0;
        if (wmem && !mis) model_mem[inst][alu[9:2]] = inb;
        sb.push_back(e);

        ex_wreg = wreg; ex_m2reg = m2reg; ex_wmem = wmem;
        ex_aluR = alu; ex_inB = inb; ex_destR = dest;
        EXE_ins_type = typ; EXE_ins_number = num;

        stalls = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!o_stall[inst]) break;
            stalls++;
            checkOutput("wreg_while_stalled", {31'd0, o_wreg[inst]}, 32'd0);
        end
        checkOutput("stall_release", {31'd0, o_stall[inst]}, 32'd0);

        got = sb.pop_front();
        checkOutput("stall_cycles", stalls, got.stalls);
        checkOutput("mem_wreg",     {31'd0, o_wreg[inst]},  {31'd0, got.wreg});
        checkOutput("mem_m2reg",    {31'd0, o_m2reg[inst]}, {31'd0, got.m2reg});
        checkOutput("mem_aluR",     o_aluR[inst],  got.aluR);
        checkOutput("mem_mdata",    o_mdata[inst], got.mdata);
        checkOutput("mem_destR",    {27'd0, o_destR[inst]}, {27'd0, got.destR});
        checkOutput("MEM_ins_type", {28'd0, o_type[inst]},  {28'd0, got.typ});
        checkOutput("MEM_ins_num",  {28'd0, o_num[inst]},   {28'd0, got.num});
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("mem_misalign", {31'd0, o_mis[inst]}, {31'd0, got.mis});
`endif
    endtask

    initial begin
        rst = 1'b0;
        driveNop();
        doReset(2);

        checkOutput("rst_wreg",   {31'd0, o_wreg[0]},  32'd0);
        checkOutput("rst_m2reg",  {31'd0, o_m2reg[0]}, 32'd0);
        checkOutput("rst_aluR",   o_aluR[0],  32'd0);
        checkOutput("rst_mdata",  o_mdata[0], 32'd0);
        checkOutput("rst_destR",  {27'd0, o_destR[0]}, 32'd0);
        checkOutput("rst_type",   {28'd0, o_type[0]},  32'd0);
        checkOutput("rst_number", {28'd0, o_num[0]},   32'd0);
        for (int i = 0; i < 4; i++) checkOutput("rst_stall", {31'd0, o_stall[i]}, 32'd0);

        $display("[TB] WAIT_STATES=0: store/load, address wrap, ALU pass-through");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 5'd0,  4'd2, 4'd1);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h10,  32'd0,        5'd5,  4'd1, 4'd2);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h410, 32'h0000_BEEF, 5'd0, 4'd2, 4'd3);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h10,  32'd0,        5'd6,  4'd1, 4'd4);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h55,  32'd0,        5'd7,  4'd3, 4'd5);

        doReset(2);
        $display("[TB] WAIT_STATES=3: preload then stalled load");
        applyStimulus(2, 1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 5'd0, 4'd2, 4'd6);
        applyStimulus(2, 1'b1, 1'b1, 1'b0, 32'h20, 32'd0,        5'd9, 4'd1, 4'd7);

        doReset(2);
        $display("[TB] WAIT_STATES=2: ALU op then store then load-back");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h7,  32'd0,        5'd3,  4'd3, 4'd8);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 32'h40, 32'hA5A50F0F, 5'd0,  4'd2, 4'd9);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'd0,        5'd11, 4'd1, 4'd10);

        doReset(2);
        $display("[TB] WAIT_STATES=4: reset during WAIT abandons a store");
        applyStimulus(3, 1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 5'd0, 4'd2, 4'd11);
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_wmem = 1'b1;
        ex_aluR = 32'h30; ex_inB = 32'h11111111; ex_destR = 5'd0;
        EXE_ins_type = 4'd2; EXE_ins_number = 4'd12;
        @(negedge clk);
        checkOutput("abort_stall_idle", {31'd0, o_stall[3]}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_stall_wait2", {31'd0, o_stall[3]}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_stall_drop", {31'd0, o_stall[3]}, 32'd0);
        checkOutput("abort_wreg",       {31'd0, o_wreg[3]},  32'd0);
        checkOutput("abort_aluR",       o_aluR[3], 32'd0);
        rst = 1'b1;
        driveNop();
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 32'h30, 32'd0, 5'd12, 4'd1, 4'd13);

`ifdef MEM_ALIGN_CHECK_EN
        doReset(2);
        $display("[TB] align check: misaligned store suppressed, misaligned load no write-back");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h30, 32'h0BADF00D, 5'd0,  4'd2, 4'd14);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h31, 32'h11112222, 5'd0,  4'd2, 4'd15);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'd0,        5'd13, 4'd1, 4'd0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h32, 32'd0,        5'd14, 4'd1, 4'd1);
`endif

        driveNop();
        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Holds the EXE/MEM pipeline register and an internal word-addressed data RAM.
- Performs loads and stores with a configurable number of wait states.
- Stalls upstream stages while an access is in progress, and presents the ALU result or load data plus write-back controls to the write-back stage.

Parameters:
- DEPTH, 256: data RAM words; must be a power of 2.
- ADDR_W, 8: word index width; must equal log2(DEPTH).
- WAIT_STATES, 0: extra cycles per load/store, 0..15.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- ex_wreg  in  1  register write enable from the execute stage.
- ex_m2reg  in  1  load select (write-back from memory).
- ex_wmem  in  1  store enable.
- ex_aluR  in  32  ALU result / effective address.
- ex_inB  in  32  store data.
- ex_destR  in  5  destination register.
- EXE_ins_type  in  4  debug instruction type.
- EXE_ins_number  in  4  debug instruction number.
- mem_stall  out  1  high: the IF/ID/EX stages must hold their state.
- mem_wreg  out  1  write-back enable (qualified).
- mem_m2reg  out  1  load select to the write-back stage.
- mem_aluR  out  32  registered ALU result.
- mem_mdata  out  32  load data.
- mem_destR  out  5  registered destination register.
- MEM_ins_type  out  4  registered debug type.
- MEM_ins_number  out  4  registered debug number.
- mem_misalign  out  1  alignment error flag; present only with the optional feature.

Behaviour:
- Reset: with rst=0 at a clock edge, the following are cleared: all EXE/MEM register fields, the FSM (to IDLE) and the wait counter.
  - Outputs after reset: mem_stall=0, mem_wreg=0, mem_m2reg=0, mem_aluR=0, mem_mdata=0, mem_destR=0, MEM_ins_type=0, MEM_ins_number=0.
  - RAM contents are not reset.
- EXE/MEM register:
  - Loads all ex_* and EXE_* inputs on each edge where mem_stall=0.
  - Holds its value while mem_stall=1.
- Address: word index = aluR[ADDR_W+1:2]. The upper bits are ignored, so addresses wrap modulo DEPTH words.
- The registered instruction is a memory op when m2reg=1 or wmem=1. If both are set, the op is treated as a store, and mem_m2reg is still driven from the register.
- FSM states: IDLE and WAIT.
  - IDLE, WAIT_STATES=0 or not a memory op: the access completes in the cycle following the latch.
    - mem_stall=0.
    - A store writes the RAM at the next edge.
    - A load drives mem_mdata from an asynchronous RAM read.
  - IDLE, WAIT_STATES>0 and a memory op:
    - At the first edge, the counter is set to WAIT_STATES-1 and the FSM moves to WAIT.
    - mem_stall=1 combinationally from the latch cycle onward.
    - Total stall = WAIT_STATES cycles.
  - WAIT: mem_stall=1 and the counter decrements each edge. When counter=0, the next edge returns the FSM to IDLE.
  - Store commit: exactly once, at the edge leaving the final access cycle (stall low). Never while stalled.
  - Load data: mem_mdata is valid in the final access cycle.
- mem_wreg = registered wreg AND NOT mem_stall, so write-back sees at most one valid write per instruction.
- mem_mdata = RAM[index] when registered m2reg=1, otherwise 0.
- Back-to-back memory ops: the next op is latched on the release edge and its access starts immediately. There are no idle cycles beyond the WAIT_STATES stall per op.
- Store followed by a load to the same address: the load returns the newly stored value (the store commits before the load cycle).
- Reset during WAIT: the FSM goes to IDLE, mem_stall drops on the following cycle, and the pending store is abandoned (no RAM write).
- Non-memory ops pass through without stalling, regardless of WAIT_STATES.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: mem_misalign = memory op AND aluR[1:0]!=0.
  - A misaligned store is suppressed (no RAM write).
  - A misaligned load forces mem_wreg=0.
  - The stall timing is unchanged.
- Not defined: the mem_misalign port is absent, aluR[1:0] is ignored, and every access proceeds.

Test Plan:
- rst=0 for 2 cycles, then released → all outputs 0, mem_stall=0.
- WAIT_STATES=0: store 0xDEADBEEF to address 0x10, then load from 0x10 with destR=5 → in the load's MEM cycle, mem_mdata=0xDEADBEEF, mem_wreg=1, mem_destR=5, no stall.
- WAIT_STATES=3: load from 0x20 (preloaded 0x12345678) → mem_stall high for exactly 3 cycles, mem_wreg=0 while stalled, then mem_mdata=0x12345678 with mem_wreg=1 for 1 cycle; upstream inputs held.
- WAIT_STATES=2: ALU op (wreg=1, aluR=7) → no stall, mem_aluR=7 on the next cycle; an immediately following store incurs 2 stall cycles and writes once.
- WAIT_STATES=4: assert rst=0 in the second WAIT cycle of a store to 0x30 → stall drops, RAM[0x30>>2] unchanged.
- MEM_ALIGN_CHECK_EN defined: store to 0x31 → mem_misalign=1, RAM unchanged; load from 0x32 → mem_wreg=0.
